// File: rtl/agt_arb_pkg.sv
// Shared types and default constants for the agt packet-locking round-robin arbiter.
package agt_arb_pkg;

  localparam int unsigned AGT_ARB_NUM_REQ     = 4;
  localparam int unsigned AGT_ARB_DATA_W      = 32;
  localparam int unsigned AGT_ARB_TIMEOUT_CYC = 256;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned agt_arb_id_w(input int unsigned num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/agt_rr_pick.sv
// Combinational round-robin pick: first set request at or above rr_ptr, with wrap.
module agt_rr_pick
  import agt_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = AGT_ARB_NUM_REQ,
  localparam int unsigned ID_W    = agt_arb_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  localparam int unsigned SUM_W = ID_W + 1;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W-1:0]      off;
  logic [SUM_W-1:0]     sum;

  // Rotate so rr_ptr lands on bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    dbl = {req, req} >> rr_ptr;
    rot = dbl[NUM_REQ-1:0];
    off = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, off} + {1'b0, rr_ptr};
    if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
    winner  = sum[ID_W-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/agt_rr_arbiter.sv
// Packet-locking round-robin arbiter onto one shared valid/ready channel.
// Optional stall watchdog is compiled in with `define AGT_ARB_WDOG_EN.
module agt_rr_arbiter
  import agt_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = AGT_ARB_NUM_REQ,
  parameter  int unsigned DATA_W      = AGT_ARB_DATA_W,
  parameter  int unsigned TIMEOUT_CYC = AGT_ARB_TIMEOUT_CYC,
  localparam int unsigned ID_W        = agt_arb_id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_last,
  output logic [ID_W-1:0]           m_id,
  input  logic                      wdog_clr,
  output logic                      wdog_err
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] pick_winner;
  logic            pick_any;

  agt_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .winner  (pick_winner),
    .any_req (pick_any)
  );

  // Next state plus the zero-latency mux from the locked requester to the shared channel.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    m_id      = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_winner;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        m_valid            = req_valid[grant_q];
        m_data             = req_data[grant_q*DATA_W +: DATA_W];
        m_last             = req_last[grant_q];
        m_id               = grant_q;
        req_ready[grant_q] = m_ready;
        if (m_valid && m_ready && m_last) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef AGT_ARB_WDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             wdog_err_q, wdog_err_d;
  logic             stall_c;

  // Saturating stall counter; a trigger in the same cycle as a clear keeps the flag set.
  always_comb begin
    stall_c     = (state_q == ARB_BUSY) && !(m_valid && m_ready);
    stall_cnt_d = '0;
    if (stall_c) begin
      stall_cnt_d = (stall_cnt_q == CNT_W'(TIMEOUT_CYC)) ? stall_cnt_q
                                                         : stall_cnt_q + CNT_W'(1);
    end
    wdog_err_d = wdog_err_q;
    if (wdog_clr) wdog_err_d = 1'b0;
    if (stall_c && (stall_cnt_d == CNT_W'(TIMEOUT_CYC))) wdog_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      wdog_err_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      wdog_err_q  <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  logic wdog_unused_c;
  assign wdog_unused_c = wdog_clr ^ (TIMEOUT_CYC == 0);
  assign wdog_err      = 1'b0;
`endif

endmodule
